program_counter: RTL and testbench
==================================

# program_counter

Program counter register for the single-cycle MIPS core. Holds the address of the instruction being fetched and computes the next address each clock from the previous PC, the control unit's increment type, the ALU branch condition and the decoded jump and branch operands. The PC value is fed back externally: the parent wires `current_pc` into `last_pc`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `last_pc`  in  32  previous PC, the base for sequential and branch computation. Connected to `current_pc` by the parent.
- `pc_inc_type`  in  2  next-PC select from the control unit.
- `alu_branch_result`  in  1  branch condition from the ALU; 1 means taken.
- `abs_addr`  in  32  absolute jump target, a full byte address.
- `branch_addr`  in  32  sign-extended branch offset, in words.
- `current_pc`  out  32  registered PC.

## Operation
- `seq` = `last_pc` + 4.
- `br_tgt` = `last_pc` + 4 + (`branch_addr` << 2).
- Both sums are 32-bit, modulo 2^32; wrap-around is silent and no carry or overflow is flagged.
- `pc_inc_type` encoding:
  - 2'b00 NORMAL: next = `seq`.
  - 2'b01 BRANCH: next = `br_tgt` if `alu_branch_result` is 1, else `seq`.
  - 2'b10 JUMP: next = `abs_addr`, used unmodified.
  - 2'b11 HOLD: next = `last_pc` (stall).
- `alu_branch_result` is ignored in every mode except BRANCH.
- Low two bits are not forced. A misaligned `abs_addr` propagates as given, and alignment is the caller's responsibility.
- No X-propagation guard. Inputs are assumed driven whenever `clr` is 0.

## Timing
- `current_pc` is a 32-bit register.
- `clr` = 1 forces `current_pc` to `RESET_PC` immediately, with no clock needed. The reset value is held while `clr` is high, regardless of the other inputs.
- Reset deassertion: the first rising edge with `clr` = 0 loads next = f(`last_pc` = `RESET_PC`, inputs).
- Latency: one cycle. Inputs sampled at edge N appear on `current_pc` after edge N, within clk-to-q.
- Next-PC logic is purely combinational from the inputs. There is no combinational path from inputs to `current_pc`.
- Reset asserted mid-operation overrides any pending jump or branch. Nothing is remembered across reset.

## Structure
- Shared package `pc_pkg` holds:
  - enum `pc_inc_t` { PC_INC_NORMAL = 2'b00, PC_INC_BRANCH = 2'b01, PC_INC_JUMP = 2'b10, PC_INC_HOLD = 2'b11 }
  - `PC_STEP` = 32'd4
  - `RESET_PC_DEFAULT`
- The control unit imports the same enum.
- Sub-module `pc_next`: a combinational next-PC calculator (adders plus 4-way mux). The top level is only this calculator and the async-clear register.

## Test plan
- Reset:
  - `clr` = 1, all other inputs random → `current_pc` = 0 within 1 ns, with no clock edge.
  - Hold 3 cycles → `current_pc` stays 0.
- Sequential run: release `clr` with NORMAL → `current_pc` = 4, 8, 0xC on successive edges.
- Branch:
  - `current_pc` = 0x10, BRANCH, `branch_addr` = 0x3, taken = 1 → 0x20.
  - Same inputs with taken = 0 → 0x14.
  - Negative offset: from 0x20, `branch_addr` = 0xFFFF_FFFC, taken = 1 → 0x14.
- Jump and hold:
  - JUMP with `abs_addr` = 0x0040_0100 → 0x0040_0100.
  - Then HOLD for 2 cycles → stays 0x0040_0100.
  - Then JUMP with `alu_branch_result` toggling → value unaffected by the branch input.
- Wrap and reset mid-run:
  - JUMP to 0xFFFF_FFFC, then NORMAL → 0x0000_0000.
  - Assert `clr` between edges during a pending BRANCH → 0 immediately; the next edge after release gives 4 with NORMAL.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter and the control unit that drives it.
// Holds the next-PC select encoding, the sequential step size and the reset address.
package pc_pkg;

   typedef enum logic [1:0] {
      PC_INC_NORMAL = 2'b00,
      PC_INC_BRANCH = 2'b01,
      PC_INC_JUMP   = 2'b10,
      PC_INC_HOLD   = 2'b11
   } pc_inc_t;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Branch offsets are in words; the target is relative to the sequential PC.
   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [31:0] word_offset);
      return pc + PC_STEP + (word_offset << 2);
   endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC calculator: sequential and branch adders feeding a 4-way select.
// All arithmetic wraps modulo 2^32; no alignment is imposed on any target.
module pc_next
   import pc_pkg::*;
(
   input  logic [31:0] last_pc,
   input  logic [1:0]  pc_inc_type,
   input  logic        alu_branch_result,
   input  logic [31:0] abs_addr,
   input  logic [31:0] branch_addr,
   output logic [31:0] next_pc
);

   logic [31:0] seq_pc;
   logic [31:0] br_tgt;

   always_comb begin
      seq_pc = last_pc + PC_STEP;
      br_tgt = branch_target(last_pc, branch_addr);
   end

   always_comb begin
      next_pc = seq_pc;
      unique case (pc_inc_t'(pc_inc_type))
         PC_INC_NORMAL: next_pc = seq_pc;
         PC_INC_BRANCH: next_pc = alu_branch_result ? br_tgt : seq_pc;
         PC_INC_JUMP:   next_pc = abs_addr;
         PC_INC_HOLD:   next_pc = last_pc;
         default:       next_pc = seq_pc;
      endcase
   end

endmodule

// File: rtl/program_counter.sv
// PC register of the single-cycle MIPS core: next-PC calculator plus an async-clear register.
// The parent feeds current_pc back into last_pc.
module program_counter
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] last_pc,
   input  logic [1:0]  pc_inc_type,
   input  logic        alu_branch_result,
   input  logic [31:0] abs_addr,
   input  logic [31:0] branch_addr,
   output logic [31:0] current_pc
);

   logic [31:0] next_pc;
   logic [31:0] current_pc_d;
   logic [31:0] current_pc_q;

   pc_next u_pc_next (
      .last_pc           (last_pc),
      .pc_inc_type       (pc_inc_type),
      .alu_branch_result (alu_branch_result),
      .abs_addr          (abs_addr),
      .branch_addr       (branch_addr),
      .next_pc           (next_pc)
   );

   always_comb begin
      current_pc_d = next_pc;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         current_pc_q <= RESET_PC;
      end else begin
         current_pc_q <= current_pc_d;
      end
   end

   assign current_pc = current_pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a reference model pushes expected PCs into a
// scoreboard as each cycle's stimulus is driven; each test pops and compares after the edge.
module tb_program_counter;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [1:0]  T_NORMAL = 2'b00;
   localparam logic [1:0]  T_BRANCH = 2'b01;
   localparam logic [1:0]  T_JUMP   = 2'b10;
   localparam logic [1:0]  T_HOLD   = 2'b11;

   logic        clk;
   logic        clr;
   logic [1:0]  pc_inc_type;
   logic        alu_branch_result;
   logic [31:0] abs_addr;
   logic [31:0] branch_addr;
   logic [31:0] current_pc;

   logic [31:0] sb[$];
   logic [31:0] model_pc;
   logic [31:0] exp_pc;
   int          n_cmp;
   int          n_err;

   program_counter #(
      .RESET_PC (RST_PC)
   ) dut (
      .clk               (clk),
      .clr               (clr),
      .last_pc           (current_pc),
      .pc_inc_type       (pc_inc_type),
      .alu_branch_result (alu_branch_result),
      .abs_addr          (abs_addr),
      .branch_addr       (branch_addr),
      .current_pc        (current_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] t,
                                              input logic tk, input logic [31:0] ja,
                                              input logic [31:0] bo);
      case (t)
         T_NORMAL: return pc + 32'd4;
         T_BRANCH: return tk ? (pc + 32'd4 + {bo[29:0], 2'b00}) : (pc + 32'd4);
         T_JUMP:   return ja;
         default:  return pc;
      endcase
   endfunction

   // Called 1 ns after an active edge; drives one cycle and pushes the model's expectation.
   task automatic step(input logic [1:0] t, input logic tk, input logic [31:0] ja,
                       input logic [31:0] bo);
      pc_inc_type       = t;
      alu_branch_result = tk;
      abs_addr          = ja;
      branch_addr       = bo;
      model_pc          = model_next(model_pc, t, tk, ja, bo);
      sb.push_back(model_pc);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr               = 1'b0;
      pc_inc_type       = 2'($urandom);
      alu_branch_result = 1'($urandom);
      abs_addr          = $urandom;
      branch_addr       = $urandom;
      #2;
      clr = 1'b1;
      #1;
      model_pc = RST_PC;
      n_cmp++;
      if (current_pc !== model_pc) begin
         $display("FAIL reset_async: got %h expected %h", current_pc, model_pc);
         n_err++;
      end
      for (int i = 0; i < 3; i++) begin
         pc_inc_type       = 2'($urandom);
         alu_branch_result = 1'($urandom);
         abs_addr          = $urandom;
         branch_addr       = $urandom;
         @(posedge clk);
         #1;
         n_cmp++;
         if (current_pc !== model_pc) begin
            $display("FAIL reset_hold_%0d: got %h expected %h", i, current_pc, model_pc);
            n_err++;
         end
      end
   endtask

   task automatic test_sequential();
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(T_NORMAL, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100);
         exp_pc = sb.pop_front();
         n_cmp++;
         if (current_pc !== exp_pc) begin
            $display("FAIL seq_%0d: got %h expected %h", i, current_pc, exp_pc);
            n_err++;
         end
      end
   endtask

   task automatic test_branch();
      // {type, taken, abs, offset}
      logic [1:0]  t[6]  = '{T_NORMAL, T_BRANCH, T_JUMP, T_BRANCH, T_JUMP, T_BRANCH};
      logic        tk[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] ja[6] = '{32'h0, 32'h0, 32'h10, 32'h0, 32'h20, 32'h0};
      logic [31:0] bo[6] = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h3, 32'hFFFF_FFFC};
      for (int i = 0; i < 6; i++) begin
         step(t[i], tk[i], ja[i], bo[i]);
         exp_pc = sb.pop_front();
         n_cmp++;
         if (current_pc !== exp_pc) begin
            $display("FAIL branch_%0d: got %h expected %h", i, current_pc, exp_pc);
            n_err++;
         end
      end
   endtask

   task automatic test_jump_hold();
      logic [1:0]  t[6]  = '{T_JUMP, T_HOLD, T_HOLD, T_JUMP, T_JUMP, T_NORMAL};
      logic        tk[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ja[6] = '{32'h0040_0100, 32'h0, 32'h0, 32'h0040_0203, 32'h0040_0300, 32'h0};
      for (int i = 0; i < 6; i++) begin
         step(t[i], tk[i], ja[i], 32'h0000_0040);
         exp_pc = sb.pop_front();
         n_cmp++;
         if (current_pc !== exp_pc) begin
            $display("FAIL jump_hold_%0d: got %h expected %h", i, current_pc, exp_pc);
            n_err++;
         end
      end
   endtask

   task automatic test_wrap();
      step(T_JUMP, 1'b0, 32'hFFFF_FFFC, 32'h0);
      step(T_NORMAL, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         exp_pc = sb.pop_front();
         n_cmp++;
         if (current_pc !== exp_pc && i == 1) begin
            $display("FAIL wrap: got %h expected %h", current_pc, exp_pc);
            n_err++;
         end
      end
   endtask

   task automatic test_reset_mid_run();
      step(T_JUMP, 1'b0, 32'h0000_1000, 32'h0);
      exp_pc = sb.pop_front();
      n_cmp++;
      if (current_pc !== exp_pc) begin
         $display("FAIL mid_pre: got %h expected %h", current_pc, exp_pc);
         n_err++;
      end
      pc_inc_type       = T_BRANCH;
      alu_branch_result = 1'b1;
      branch_addr       = 32'h0000_0010;
      #2;
      clr = 1'b1;
      #1;
      model_pc = RST_PC;
      n_cmp++;
      if (current_pc !== model_pc) begin
         $display("FAIL mid_clr_async: got %h expected %h", current_pc, model_pc);
         n_err++;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (current_pc !== model_pc) begin
         $display("FAIL mid_clr_hold: got %h expected %h", current_pc, model_pc);
         n_err++;
      end
      clr = 1'b0;
      step(T_NORMAL, 1'b1, 32'h0, 32'h0000_0010);
      exp_pc = sb.pop_front();
      n_cmp++;
      if (current_pc !== exp_pc) begin
         $display("FAIL mid_release: got %h expected %h", current_pc, exp_pc);
         n_err++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
         n_err++;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_sequential();
      test_branch();
      test_jump_hold();
      test_wrap();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
